aes_128_out_serializer: RTL
===========================

Name: aes_128_out_serializer

Overview:
Downstream stage of the multicycle aes_128 core. Captures each 128-bit ciphertext block on the core's one-cycle valid pulse into a small block FIFO. Emits it as four 32-bit words on a valid/ready stream, most-significant word first, with last marking word 3. Decouples the core's fixed-latency output from a back-pressuring consumer (bus bridge or file-dump monitor).

Parameters:
DEPTH, 2, number of 128-bit blocks buffered (power of two, >=2)
LEVEL_W, $clog2(DEPTH+1), width of the fill-level output

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
blk_valid  input  1  one-cycle pulse from the core's valid; blk_data is valid this cycle only
blk_data  input  128  ciphertext from the core's out_bus
m_data  output  32  current output word
m_valid  output  1  m_data is valid
m_ready  input  1  consumer accepts m_data
m_last  output  1  high with word 3 of a block
overflow  output  1  sticky: a block was dropped
clr_overflow  input  1  synchronous clear of overflow
level  output  LEVEL_W  blocks currently stored, including the one being serialized

Behaviour:
- Reset (async, rst_n=0): m_valid=0, m_last=0, m_data=0, overflow=0, level=0; word index=0; FIFO pointers=0. Reset mid-block discards all stored and partial data; no word is emitted after release until a new blk_valid.
- Word order: word 0 = blk_data[127:96], word 1 = [95:64], word 2 = [63:32], word 3 = [31:0]. Matches hex print order.
- Write: blk_valid=1 and space -> block stored at tail on that edge; level increments.
- Space = (level<DEPTH), or (level==DEPTH and the word-3 handshake occurs the same cycle).
- Overflow: blk_valid=1 with no space -> block dropped, level unchanged, overflow<=1 next edge. Stays set until clr_overflow=1.
- Simultaneous clr_overflow and drop: overflow stays 1 (set wins).
- Latency: block written at edge N -> m_valid=1 with word 0 from cycle N+1. No bypass when empty.
- Output: m_valid = (level!=0). m_data = head[word index]. m_last = m_valid and (word index==3).
- Handshake: m_valid and m_ready at an edge -> word index+1.
  - At index 3: index wraps to 0, head pops, level decrements.
  - Simultaneous push and pop: level unchanged.
- Stream rules: m_data/m_last stable while m_valid and !m_ready. m_valid never drops without a handshake. m_valid/m_data never depend combinationally on m_ready.
- Throughput: 1 word/cycle with m_ready held high. Back-to-back blocks stream with no bubble between word 3 and the next word 0.
- Pointer wrap: head/tail modulo DEPTH; level saturates logic at DEPTH (never exceeds).
- blk_data ignored when blk_valid=0.

Decomposition:
- Package aes_128_pkg:
  - constants BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4
  - typedefs block_t logic[127:0], word_t logic[31:0], word_idx_t logic[1:0]
- Sub-module aes_128_block_fifo (DEPTH x block_t; push/pop/full/empty/level, registered storage, same-cycle push+pop when full allowed).
- Top holds word-index counter, word mux, overflow flag.

Test Plan:
1. Reset, then blk_valid one cycle with 3925841d02dc09fbdc118597196a0b32, m_ready=1 -> from next cycle words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles. m_last only on 196a0b32. level 1->0 after last.
2. Same block with m_ready toggling 1,0,0,1,... -> each word held stable while stalled. Exactly 4 handshakes, order unchanged.
3. m_ready=0, push 69c4e0d86a7b0430d8cdb78070b4c55a then 3925841d...0b32 -> level=2. Third push -> dropped, overflow=1, level=2. Release m_ready -> 8 words, both blocks in order. clr_overflow -> overflow=0.
4. level=2 and word-3 handshake in same cycle as blk_valid -> block accepted, overflow stays 0, level stays 2.
5. Assert rst_n=0 mid-block after word 1 -> m_valid=0, level=0 immediately (async). After release, no output until a new blk_valid.
6. Ten back-to-back blocks, one per 10 cycles, m_ready=1 -> 40 words, no gaps within blocks, never overflows.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared types and constants for the AES-128 output path.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents: block/word widths, block_t / word_t / word_idx_t typedefs and
// block_word(), which picks one 32-bit word out of a 128-bit block with
// word 0 being the most-significant word (hex print order).
package aes_128_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [1:0]         word_idx_t;

  // Word 0 is the leftmost group of eight hex digits of the block.
  function automatic word_t block_word(input block_t blk, input word_idx_t idx);
    word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_128_block_fifo.sv
// Block FIFO: DEPTH entries of 128-bit ciphertext, registered storage.
// Latency: a block pushed at edge N is visible on head_data from cycle N+1.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   push, push_data write request and block to store at the tail
//   pop             remove the head block (ignored when empty)
//   head_data       block at the head (only meaningful when !empty)
//   full, empty     occupancy flags
//   level           number of stored blocks, 0..DEPTH
module aes_128_block_fifo
  import aes_128_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  block_t             push_data,
  input  logic               pop,
  output block_t             head_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  block_t             mem [DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic               do_push;
  logic               do_pop;

  assign full  = (level == LEVEL_W'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO may still accept a block when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[head_ptr];

  // Storage carries no reset: contents are only observable while level != 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      level    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/aes_128_out_serializer.sv
// Serializes 128-bit AES ciphertext blocks into four 32-bit stream words, MS word first.
// Latency: block captured at edge N -> word 0 on m_data from cycle N+1; 1 word/cycle after.
// Backpressure: m_ready stalls the stream; blocks arriving with no buffer space are dropped (sticky overflow).
//
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   blk_valid, blk_data     one-cycle block pulse from the core
//   m_data, m_valid, m_ready, m_last  32-bit valid/ready output stream, m_last on word 3
//   overflow, clr_overflow  sticky drop flag and its synchronous clear
//   level                   blocks held, including the one being serialized
module aes_128_out_serializer
  import aes_128_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  input  logic [127:0]       blk_data,
  output logic [31:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic [LEVEL_W-1:0] level
);

  block_t    head_blk;
  logic      fifo_full;
  logic      fifo_empty;
  word_idx_t word_idx;
  logic      word_hs;
  logic      last_hs;
  logic      space;
  logic      push;
  logic      drop;

  assign m_valid = !fifo_empty;
  assign word_hs = m_valid && m_ready;
  assign last_hs = word_hs && (word_idx == 2'd3);

  // The slot freed by a word-3 handshake can be refilled on the same edge.
  assign space = !fifo_full || last_hs;
  assign push  = blk_valid && space;
  assign drop  = blk_valid && !space;

  aes_128_block_fifo #(
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (blk_data),
    .pop       (last_hs),
    .head_data (head_blk),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Output is driven to zero when idle so the unreset storage never leaks out.
  assign m_data = m_valid ? block_word(head_blk, word_idx) : '0;
  assign m_last = m_valid && (word_idx == 2'd3);

  // Two-bit index wraps 3 -> 0 on its own, in step with the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
    end else if (word_hs) begin
      word_idx <= word_idx + 2'd1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
